// File: rtl/floo_wrr_link_arbiter.sv
// Weighted round-robin packet arbiter feeding one link through a one-entry output register slice.
// Define FLOO_ARB_STATS_EN to build the per-input saturating packet counters on grant_cnt_o.
module floo_wrr_link_arbiter #(
    parameter int unsigned NumInp      = 4,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned WeightWidth = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumInp*WeightWidth-1:0]   weight_i,
    input  logic [NumInp-1:0]               valid_i,
    output logic [NumInp-1:0]               ready_o,
    input  logic [NumInp*DataWidth-1:0]     data_i,
    input  logic [NumInp-1:0]               last_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [DataWidth-1:0]            data_o,
    output logic                            last_o,
    output logic [$clog2(NumInp)-1:0]       src_o,
    output logic [NumInp*16-1:0]            grant_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumInp);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]             r_state, w_state_d;
    logic [IdxW-1:0]        r_ptr, w_ptr_d;
    logic [WeightWidth-1:0] r_credit, w_credit_d;
    logic                   r_valid;
    logic [DataWidth-1:0]   r_data;
    logic                   r_last;
    logic [IdxW-1:0]        r_src;

    logic [NumInp-1:0][WeightWidth-1:0] w_weights;
    logic [NumInp-1:0][DataWidth-1:0]   w_datas;
    logic                   w_slice_rdy;
    logic                   w_found;
    logic [IdxW-1:0]        w_scan_idx;
    logic                   w_gnt;
    logic [IdxW-1:0]        w_g;
    logic                   w_load;
    logic [WeightWidth-1:0] w_credit_eff;
    logic [WeightWidth-1:0] w_credit_dec;
    logic [IdxW-1:0]        w_ptr_inc;
    logic                   w_hs;
    logic                   w_hs_last;

    assign w_weights   = weight_i;
    assign w_datas     = data_i;
    assign w_slice_rdy = ~r_valid | ready_i;

    // First valid requester at or after ptr, wrapping.
    always_comb begin : p_scan
        logic [IdxW:0] sum;
        w_found    = 1'b0;
        w_scan_idx = '0;
        sum        = '0;
        for (int i = 0; i < NumInp; i++) begin
            sum = {1'b0, r_ptr} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(NumInp)) begin
                sum = sum - (IdxW+1)'(NumInp);
            end
            if (!w_found && valid_i[sum[IdxW-1:0]]) begin
                w_found    = 1'b1;
                w_scan_idx = sum[IdxW-1:0];
            end
        end
    end

    assign w_gnt = (r_state == StLocked) | w_found;
    assign w_g   = (r_state == StLocked) ? r_ptr : w_scan_idx;

    // A new turn loads a fresh credit; a weight of 0 counts as 1.
    assign w_load       = (r_state == StIdle) & ((w_g != r_ptr) | (r_credit == '0));
    assign w_credit_eff = !w_load                  ? r_credit :
                          (w_weights[w_g] == '0)   ? WeightWidth'(1) : w_weights[w_g];
    assign w_credit_dec = (w_credit_eff == '0) ? '0 : w_credit_eff - WeightWidth'(1);
    assign w_ptr_inc    = (w_g == IdxW'(NumInp - 1)) ? '0 : w_g + IdxW'(1);

    assign w_hs      = w_gnt & valid_i[w_g] & w_slice_rdy;
    assign w_hs_last = w_hs & last_i[w_g];

    always_comb begin
        w_state_d  = r_state;
        w_ptr_d    = r_ptr;
        w_credit_d = r_credit;
        if (w_hs_last) begin
            w_state_d = StIdle;
            if (w_credit_dec == '0) begin
                w_ptr_d    = w_ptr_inc;
                w_credit_d = '0;
            end else begin
                w_ptr_d    = w_g;
                w_credit_d = w_credit_dec;
            end
        end else if (r_state == StIdle && w_found) begin
            w_state_d  = StLocked;
            w_ptr_d    = w_g;
            w_credit_d = w_credit_eff;
        end
    end

    // Ready is gated by reset so it drops the instant reset is asserted.
    always_comb begin
        ready_o = '0;
        if (w_gnt && !rst_i) begin
            ready_o[w_g] = w_slice_rdy;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_d;
            r_ptr    <= w_ptr_d;
            r_credit <= w_credit_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_src   <= '0;
        end else if (w_hs) begin
            r_valid <= 1'b1;
            r_data  <= w_datas[w_g];
            r_last  <= last_i[w_g];
            r_src   <= w_g;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign src_o   = r_src;

`ifdef FLOO_ARB_STATS_EN
    logic [NumInp-1:0][15:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_hs_last && r_cnt[w_g] != 16'hFFFF) begin
            r_cnt[w_g] <= r_cnt[w_g] + 16'd1;
        end
    end

    assign grant_cnt_o = r_cnt;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/floo_wrr_link_arbiter.md
Name: floo_wrr_link_arbiter

Overview:
- Weighted round-robin arbiter that shares one router link between NumInp requesters, e.g. the narrow and wide NI manager streams plus local injectors feeding a router input.
- Grants whole packets: a grant holds until the flit marked last completes its handshake.
- Per-input weights set how many consecutive packets each requester may send before the grant rotates.
- Output passes through a one-entry register slice, so the downstream link sees registered valid/data.

Parameters:
- NumInp, 4, number of requesters (2..8).
- DataWidth, 64, flit payload width in bits.
- WeightWidth, 4, width of each per-input weight.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- weight_i  in  NumInp*WeightWidth  packets per turn for each input; sampled when that input's turn begins; 0 is treated as 1.
- valid_i  in  NumInp  flit valid per input.
- ready_o  out  NumInp  flit ready per input.
- data_i  in  NumInp*DataWidth  flit payload per input.
- last_i  in  NumInp  marks the last flit of a packet.
- valid_o  out  1  output flit valid.
- ready_i  in  1  downstream ready.
- data_o  out  DataWidth  output payload.
- last_o  out  1  output last flag.
- src_o  out  $clog2(NumInp)  index of the input that sourced the output flit.
- grant_cnt_o  out  NumInp*16  per-input packet counters (see Optional Feature).

Behaviour:
- Reset values: valid_o=0, data_o=0, last_o=0, src_o=0, ready_o=0, grant_cnt_o=0. Internally: state=IDLE, ptr=0, credit=0.
- Slice: holds one entry. It accepts a flit when it is empty or when ready_i=1 in the same cycle (full throughput).
  - slice_rdy = ~valid_o | ready_i.
  - Output appears 1 cycle after the input handshake. valid_o stays high and data_o/last_o/src_o stay stable until ready_i.
- State IDLE:
  - Scan valid_i in round-robin order starting at ptr.
  - First valid index g: if g != ptr, or credit==0, load credit = max(weight_i[g],1).
  - Set ptr=g and go to LOCKED in the same cycle. A combinational grant is allowed, so ready_o[g] = slice_rdy in that cycle.
  - If no input is valid, stay in IDLE and all ready_o = 0.
- State LOCKED:
  - ready_o[ptr] = slice_rdy; all other ready_o = 0.
  - On handshake with last_i[ptr]=1, decrement credit.
    - credit becomes 0: ptr = (ptr+1) mod NumInp, then go to IDLE.
    - credit still nonzero: go to IDLE keeping ptr, so the same input is preferred next.
  - A flit without last keeps the state in LOCKED.
- Fairness:
  - Lower-numbered inputs never win past ptr.
  - An input with weight W that has continuous traffic gets exactly W packets per turn.
  - A single-flit packet (valid and last together) is legal and consumes one credit.
- Boundaries:
  - A requester deasserting valid_i mid-packet keeps the lock; the arbiter waits, with no timeout.
  - A weight change while LOCKED has no effect until that input's next turn.
  - ptr wraps from NumInp-1 to 0.
  - Asserting rst_i mid-packet drops the slice contents and returns every register to its reset value immediately (asynchronous).
- Credit arithmetic is WeightWidth-bit unsigned and never underflows.

Optional Feature:
- Macro: FLOO_ARB_STATS_EN.
- When defined: grant_cnt_o[i] increments on each last-flit handshake of input i. Each counter is 16-bit and saturates at 0xFFFF. Counters reset to 0.
- When undefined: no counter registers are built and grant_cnt_o is tied to 0.

Test Plan:
- NumInp=4, all weights=1, all inputs continuously valid with 1-flit packets -> src_o sequence 0,1,2,3,0,…; valid_o high every cycle after the first.
- Weights {3,1,1,1}, all valid, 1-flit packets -> src_o pattern 0,0,0,1,2,3 repeating.
- Input 1 sends a 4-flit packet while input 2 is valid; ready_i toggles 1,0,1,1,0,1 -> all 4 flits of input 1 emitted contiguously and in order before any input-2 flit; data_o is held stable while ready_i=0.
- Weight 0 on input 2, only input 2 valid -> behaves as weight 1 and ptr advances after each packet; input 2 is re-granted, with one IDLE cycle between packets.
- rst_i pulsed during flit 2 of a 3-flit packet -> valid_o=0, ready_o=0 immediately; after release, arbitration restarts from input 0.
- With FLOO_ARB_STATS_EN defined, 70000 packets from input 3 -> grant_cnt_o[3]=0xFFFF and other counters 0. Without the macro -> grant_cnt_o=0 throughout.
